matrix_mult_seq_ctrl: RTL and testbench

Time-multiplexed controller for the N x N constant-matrix by vector multiply (C = A * B). It replaces N*N parallel shift-and-add multipliers with one shared shift_and_add instance, sequenced over N*N cycles. It holds a runtime-loadable coefficient bank for A, accepts B vectors and returns C vectors over valid/ready handshakes. It sits between the input vector source and downstream consumers as the area-reduced (LUT-saving) variant of the baseline multiplier array.

---
 rtl/matrix_mult_seq_ctrl_pkg.sv | 17 +
 rtl/matrix_mult_seq_ctrl_sadd.sv | 19 +
 rtl/matrix_mult_seq_ctrl.sv | 106 ++++++++++
 tb/tb_matrix_mult_seq_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_seq_ctrl_pkg.sv
// Shared types, widths and helpers for the time-multiplexed matrix-vector multiplier.
package matrix_mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mm_state_t;

    localparam int MM_N      = 3;
    localparam int MM_IN_W   = 2;
    localparam int MM_COEF_W = 16;
    localparam int MM_OUT_W  = 16;
    localparam int MM_PROD_W = MM_COEF_W + MM_IN_W;
    localparam int MM_IDX_W  = $clog2(MM_N * MM_N);

    function automatic int flat_idx(input int row, input int col, input int n);
        return row * n + col;
    endfunction

endpackage

// File: rtl/matrix_mult_seq_ctrl_sadd.sv
// Combinational shift-and-add multiplier: one shifted copy of a per set bit of b.
module shift_and_add #(
    parameter int A_W = 16,
    parameter int B_W = 2,
    parameter int P_W = A_W + B_W
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [P_W-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < B_W; i++) begin
            if (b[i]) p = p + (P_W'(a) << i);
        end
    end

endmodule

// File: rtl/matrix_mult_seq_ctrl.sv
// Sequenced C = A * B: one shared multiplier walks the N*N coefficient bank,
// one product per cycle, writing each C row as its last column is summed.
module matrix_mult_seq_ctrl
    import matrix_mult_pkg::*;
#(
    parameter  int N      = MM_N,
    parameter  int IN_W   = MM_IN_W,
    parameter  int COEF_W = MM_COEF_W,
    parameter  int OUT_W  = MM_OUT_W,
    localparam int NN     = N * N,
    localparam int IDX_W  = $clog2(NN),
    localparam int PROD_W = COEF_W + IN_W,
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_addr,
    input  logic [COEF_W-1:0]   cfg_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*IN_W-1:0]   b_vec,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N*OUT_W-1:0]  c_vec,
    output logic                busy
);

    mm_state_t          state, state_nx;
    logic [CNT_W-1:0]   row, col;
    logic [OUT_W-1:0]   acc, sum;
    logic [COEF_W-1:0]  coef [NN];
    logic [IN_W-1:0]    b_lat [N];
    logic [IDX_W-1:0]   rd_idx;
    logic [PROD_W-1:0]  prod;
    logic               accept, last_col, last_row;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign last_col  = (int'(col) == N - 1);
    assign last_row  = (int'(row) == N - 1);
    assign rd_idx    = IDX_W'(flat_idx(int'(row), int'(col), N));

    shift_and_add #(.A_W(COEF_W), .B_W(IN_W), .P_W(PROD_W)) u_mul (
        .a (coef[rd_idx]),
        .b (b_lat[col]),
        .p (prod)
    );

    // OUT_W-bit wrap keeps this bit-exact with the truncated full-width sum.
    assign sum = acc + OUT_W'(prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = RUN;
            RUN:  if (last_row && last_col) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row   <= '0;
            col   <= '0;
            acc   <= '0;
            c_vec <= '0;
            for (int i = 0; i < NN; i++) coef[i] <= '0;
            for (int k = 0; k < N; k++) b_lat[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Bank only changes here, so a write coinciding with an accept feeds that run.
                    if (cfg_we && int'(cfg_addr) < NN) coef[cfg_addr] <= cfg_data;
                    if (accept) begin
                        for (int k = 0; k < N; k++) b_lat[k] <= b_vec[k*IN_W +: IN_W];
                        acc <= '0;
                        row <= '0;
                        col <= '0;
                    end
                end
                RUN: begin
                    if (last_col) begin
                        c_vec[int'(row)*OUT_W +: OUT_W] <= sum;
                        acc <= '0;
                        col <= '0;
                        if (!last_row) row <= row + 1'b1;
                    end else begin
                        acc <= sum;
                        col <= col + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mult_seq_ctrl.sv
// Directed checks for matrix_mult_seq_ctrl with hand-computed results (N=3).
module tb_matrix_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  b_vec = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [47:0] c_vec;
    logic        busy;

    int checks = 0;
    int errors = 0;

    matrix_mult_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .b_vec(b_vec),
        .out_valid(out_valid), .out_ready(out_ready), .c_vec(c_vec),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] c3(input int c0, input int c1, input int c2);
        return {16'(c2), 16'(c1), 16'(c0)};
    endfunction

    task automatic cfg(input int addr, input int data);
        cfg_we = 1'b1; cfg_addr = 4'(addr); cfg_data = 16'(data);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic load_all(input int d, input int diag);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                cfg(r*3 + c, (r == c) ? diag : d);
    endtask

    task automatic start(input logic [5:0] b);
        int n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        if (n >= 40) chk("ready_timeout", 0, 1);
        in_valid = 1'b1; b_vec = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin tick(); lat++; end
        if (lat >= 50) chk("done_timeout", 0, 1);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [5:0] b, input logic [47:0] exp);
        int lat;
        start(b);
        wait_done(lat);
        chk({tag, "_c"}, c_vec, exp);
        handshake();
        chk({tag, "_ov_drop"}, out_valid, 0);
    endtask

    initial begin
        int lat, acc_n, overlap, n;
        int acc_t [3];

        // Reset state
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_c_vec", c_vec, 0);

        // Row 0 only, B=(1,2,3): 2755+2*51466+3*60744 = 287919 -> 25775
        cfg(0, 2755); cfg(1, 51466); cfg(2, 60744);
        start(6'b111001);
        chk("row0_busy", busy, 1);
        wait_done(lat);
        chk("row0_latency", lat, 9);
        chk("row0_c", c_vec, c3(25775, 0, 0));
        handshake();
        chk("row0_ov_drop", out_valid, 0);
        chk("row0_in_ready", in_ready, 1);

        // Identity, with output stall
        load_all(0, 1);
        start(6'b111001);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            chk("stall_ov", out_valid, 1);
            chk("stall_c", c_vec, c3(1, 2, 3));
            chk("stall_in_ready", in_ready, 0);
            tick();
        end
        handshake();
        chk("ident_c_hold", c_vec, c3(1, 2, 3));

        // Config write during RUN is dropped
        start(6'b111001);
        tick(); tick();
        cfg(0, 7);
        wait_done(lat);
        chk("cfg_run_c", c_vec, c3(1, 2, 3));
        handshake();
        run("cfg_run_next", 6'b000001, c3(1, 0, 0));

        // Config write in IDLE takes effect
        cfg(0, 7);
        run("cfg_idle", 6'b000001, c3(7, 0, 0));

        // Write coinciding with accept lands first
        cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 16'd5;
        start(6'b000001);
        cfg_we = 1'b0;
        wait_done(lat);
        chk("cfg_same_cycle_c", c_vec, c3(5, 0, 0));
        handshake();

        // Out-of-range address ignored
        cfg(9, 99); cfg(15, 99);
        run("cfg_oob", 6'b010101, c3(5, 1, 1));

        // Back-to-back accepts
        in_valid = 1'b1; b_vec = 6'b010101; out_ready = 1'b1;
        acc_n = 0; overlap = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (in_valid && in_ready && acc_n < 3) begin acc_t[acc_n] = cyc; acc_n++; end
            if (in_ready && out_valid) overlap++;
            tick();
        end
        in_valid = 1'b0;
        chk("b2b_accepts", acc_n, 3);
        chk("b2b_gap0", acc_t[1] - acc_t[0], 11);
        chk("b2b_gap1", acc_t[2] - acc_t[1], 11);
        chk("b2b_overlap", overlap, 0);
        n = 0;
        while (!in_ready && n < 40) begin tick(); n++; end
        out_ready = 1'b0;
        chk("b2b_drain", in_ready, 1);

        // Wrap: 65535*3*3 = 589815 -> 65527
        load_all(65535, 65535);
        run("wrap", 6'b111111, c3(65527, 65527, 65527));

        // Reset in the 4th RUN cycle
        start(6'b111111);
        tick(); tick(); tick();
        chk("midrun_busy", busy, 1);
        rst = 1'b1;
        #2;
        chk("midrun_ov", out_valid, 0);
        chk("midrun_c", c_vec, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("midrun_in_ready", in_ready, 1);
        chk("midrun_busy_clr", busy, 0);
        run("coef_cleared", 6'b111111, c3(0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
